// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions: opcodes, fetch FSM encoding, instruction field positions.
package instr_fetch_unit_pkg;

    // Opcodes understood by the single-cycle core decoder.
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b010000;
    localparam logic [5:0] OP_OR   = 6'b010001;
    localparam logic [5:0] OP_XOR  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_JMP  = 6'b110010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Fetch FSM encoding (kept as plain constants for legacy tools).
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE   = 2'd0;
    localparam fetch_state_t ST_FETCH  = 2'd1;
    localparam fetch_state_t ST_EXEC   = 2'd2;
    localparam fetch_state_t ST_HALTED = 2'd3;

    // Instruction field bit positions.
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int TGT_MSB  = 25;
    localparam int TGT_LSB  = 0;

    // Branch displacement in bytes: sign-extended word offset shifted left by two.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory handshake plus the decoder-facing fields.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [5:0]  operation;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] pc_out;
    logic        pc_wre;
    logic        pc_src;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, instr_valid, operation, rs, rt, rd, imm16, pc_out,
        input  imem_ack, imem_rdata, pc_wre, pc_src
    );

    // Memory / decoder side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, operation, rs, rt, rd, imm16, pc_out,
        output imem_ack, imem_rdata, pc_wre, pc_src
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or region jump.
module next_pc_calc #(
    parameter logic [5:0] OP_JMP = instr_fetch_unit_pkg::OP_JMP
) (
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        pc_src,
    output logic [31:0] next_pc
);
    import instr_fetch_unit_pkg::*;

    logic [31:0] pc4_s;

    // Pick the successor address; jump keeps the top nibble of pc+4.
    always_comb begin
        pc4_s   = pc + 32'd4;
        next_pc = pc4_s;
        if (!pc_src) begin
            next_pc = pc4_s;
        end else if (ir[OPC_MSB:OPC_LSB] == OP_JMP) begin
            next_pc = {pc4_s[31:28], ir[TGT_MSB:TGT_LSB], 2'b00};
        end else begin
            next_pc = pc4_s + branch_offset(ir[IMM_MSB:IMM_LSB]);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns PC and IR, fetches over req/ack, hands fields to the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  OP_JMP   = instr_fetch_unit_pkg::OP_JMP
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    instr_fetch_unit_if.master        bus,
    output logic                      halted,
    output logic [31:0]               retired
);
    import instr_fetch_unit_pkg::*;

    fetch_state_t state_r;
    fetch_state_t state_s;
    logic [31:0]  pc_r;
    logic [31:0]  ir_r;
    logic [31:0]  retired_r;
    logic         imem_req_r;
    logic         instr_valid_r;
    logic         halted_r;
    logic [31:0]  next_pc_s;

    next_pc_calc #(.OP_JMP(OP_JMP)) u_next_pc (
        .pc      (pc_r),
        .ir      (ir_r),
        .pc_src  (bus.pc_src),
        .next_pc (next_pc_s)
    );

    // Next-state logic; decoder inputs only matter in EXEC.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) state_s = ST_FETCH;
                else     state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.imem_ack) state_s = ST_EXEC;
                else              state_s = ST_FETCH;
            end
            ST_EXEC: begin
                if (bus.pc_wre) state_s = ST_FETCH;
                else            state_s = ST_HALTED;
            end
            ST_HALTED: state_s = ST_HALTED;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State, PC, IR, retire counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            ir_r          <= 32'd0;
            retired_r     <= 32'd0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            imem_req_r    <= (state_s == ST_FETCH);
            instr_valid_r <= (state_s == ST_EXEC);
            halted_r      <= (state_s == ST_HALTED);
            // Acks outside FETCH never touch IR.
            if ((state_r == ST_FETCH) && bus.imem_ack) begin
                ir_r <= bus.imem_rdata;
            end else begin
                ir_r <= ir_r;
            end
            // Only a write-enabled EXEC advances the PC and retires.
            if ((state_r == ST_EXEC) && bus.pc_wre) begin
                pc_r      <= next_pc_s;
                retired_r <= retired_r + 32'd1;
            end else begin
                pc_r      <= pc_r;
                retired_r <= retired_r;
            end
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.operation   = ir_r[OPC_MSB:OPC_LSB];
    assign bus.rs          = ir_r[RS_MSB:RS_LSB];
    assign bus.rt          = ir_r[RT_MSB:RT_LSB];
    assign bus.rd          = ir_r[RD_MSB:RD_LSB];
    assign bus.imm16       = ir_r[IMM_MSB:IMM_LSB];
    assign bus.pc_out      = pc_r;
    assign halted          = halted_r;
    assign retired         = retired_r;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural memory/decoder model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        run;
    logic        halted;
    logic [31:0] retired;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bus     (bus),
        .halted  (halted),
        .retired (retired)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] ret;
    } item_t;

    item_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_pc;
    logic [31:0] model_retired;
    logic        strict_idle = 1'b0;
    logic        last_ack = 1'b0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endfunction

    // Reference next PC from the architectural rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word, input logic src);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (!src) return pc4;
        if ((word >> 26) == 32'd50)
            return (pc4 & 32'hF000_0000) + ((word & 32'h03FF_FFFF) * 32'd4);
        off = int'(word & 32'h0000_FFFF);
        if (off > 32767) off = off - 65536;
        return pc4 + 32'(off * 4);
    endfunction

    // Remember whether ack was present at each active edge.
    always @(posedge clk) begin
        last_ack <= bus.imem_ack;
    end

    // Monitor: checks fetch address while requesting, pops and checks on instr_valid.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_req && exp_q.size() > 0) begin
                check("fetch_addr", bus.imem_addr, exp_q[0].addr);
            end else if (bus.imem_req && strict_idle) begin
                check("req_when_halted", 32'(bus.imem_req), 32'd0);
            end
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(bus.instr_valid), 32'd0);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("exec_after_ack", 32'(last_ack), 32'd1);
                    check("pc_out", bus.pc_out, it.addr);
                    check("operation", 32'(bus.operation), it.word >> 26);
                    check("rs", 32'(bus.rs), (it.word >> 21) & 32'd31);
                    check("rt", 32'(bus.rt), (it.word >> 16) & 32'd31);
                    check("rd", 32'(bus.rd), (it.word >> 11) & 32'd31);
                    check("imm16", 32'(bus.imm16), it.word & 32'h0000_FFFF);
                    check("retired_in_exec", retired, it.ret);
                    check("halted_in_exec", 32'(halted), 32'd0);
                end
            end
        end
    end

    // Memory + decoder stand-in for one instruction; ends at the negedge after EXEC.
    task automatic fetch_one(input logic [31:0] word, input int delay, input logic wre, input logic src);
        item_t it;
        bit    found;
        it.addr = model_pc;
        it.word = word;
        it.ret  = model_retired;
        exp_q.push_back(it);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            check("req_timeout", 32'd0, 32'd1);
            exp_q.delete();
            return;
        end
        repeat (delay) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        bus.pc_wre     = wre;
        bus.pc_src     = src;
        if (wre) begin
            model_pc      = ref_next(model_pc, word, src);
            model_retired = model_retired + 32'd1;
        end
        @(negedge clk);
        bus.pc_wre = 1'($urandom);
        bus.pc_src = 1'($urandom);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [31:0] w;
        logic [5:0]  opc;
        logic [31:0] saved_ret;
        logic [31:0] saved_pc;
        bit          found;

        reset = 1'b1;
        run = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.pc_wre = 1'b0;
        bus.pc_src = 1'b0;
        model_pc = 32'd0;
        model_retired = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_operation", 32'(bus.operation), 32'd0);
        check("rst_imm16", 32'(bus.imm16), 32'd0);

        run = 1'b1;
        fetch_one(32'h0000_0000, 0, 1'b1, 1'b0);
        check("first_next_addr", bus.imem_addr, 32'd4);
        check("first_retired", retired, 32'd1);
        run = 1'b0;
        fetch_one(32'h0022_1800, 3, 1'b1, 1'b0);

        fetch_one({6'b110010, 26'h000_0004}, 0, 1'b1, 1'b1);
        check("jmp_to_10", bus.imem_addr, 32'h0000_0010);
        fetch_one({6'b110000, 5'd1, 5'd2, 16'hFFFE}, 1, 1'b1, 1'b1);
        check("branch_back", bus.imem_addr, 32'h0000_000C);
        fetch_one({6'b110010, 26'h000_0004}, 0, 1'b1, 1'b1);
        fetch_one({6'b110000, 5'd3, 5'd4, 16'h0003}, 2, 1'b1, 1'b1);
        check("branch_fwd", bus.imem_addr, 32'h0000_0020);
        fetch_one({6'b110010, 26'h3FF_FFFF}, 0, 1'b1, 1'b1);
        check("jmp_region_end", bus.imem_addr, 32'h0FFF_FFFC);
        fetch_one(32'h0000_0000, 0, 1'b1, 1'b0);
        fetch_one(32'h0000_0000, 0, 1'b1, 1'b0);
        fetch_one(32'h0000_0000, 0, 1'b1, 1'b0);
        fetch_one({6'b110010, 26'h000_0040}, 0, 1'b1, 1'b1);
        check("jmp_region1", bus.imem_addr, 32'h1000_0100);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: opc = 6'b110010;
                1: opc = 6'b110000;
                2: opc = 6'b000000;
                default: opc = 6'($urandom);
            endcase
            w = {opc, 26'($urandom)};
            fetch_one(w, int'($urandom_range(0, 3)), 1'b1, 1'($urandom));
        end
        check("retired_after_random", retired, model_retired);

        fetch_one({6'b111111, 26'h155_5555}, 1, 1'b0, 1'($urandom));
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_req", 32'(bus.imem_req), 32'd0);
        check("halt_retired", retired, model_retired);
        saved_ret = retired;
        saved_pc = model_pc;
        strict_idle = 1'b1;
        for (int n = 0; n < 6; n++) begin
            run = 1'($urandom);
            bus.imem_ack = 1'b1;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            check("halt_stays", 32'(halted), 32'd1);
            check("halt_ret_hold", retired, saved_ret);
            check("halt_pc_hold", bus.pc_out, saved_pc);
            check("halt_ir_hold", 32'(bus.operation), 32'h3F);
        end
        strict_idle = 1'b0;
        bus.imem_ack = 1'b0;

        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;
        model_pc = 32'd0;
        model_retired = 32'd0;
        exp_q.delete();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
        end
        check("req_after_reset", 32'(found), 32'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        check("midfetch_req", 32'(bus.imem_req), 32'd0);
        check("midfetch_ir_op", 32'(bus.operation), 32'd0);
        check("midfetch_ir_imm", 32'(bus.imm16), 32'd0);
        check("midfetch_pc", bus.pc_out, 32'd0);
        check("midfetch_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("late_ack_ir", 32'(bus.operation), 32'd0);
        check("late_ack_req", 32'(bus.imem_req), 32'd0);
        bus.imem_ack = 1'b0;

        run = 1'b1;
        fetch_one({6'b110000, 10'd0, 16'hFFFE}, 0, 1'b1, 1'b1);
        check("to_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0000, 1, 1'b1, 1'b0);
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);
        check("wrap_retired", retired, 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Sequential front end that owns the PC. It fetches each instruction from instruction memory over a req/ack handshake and presents the latched instruction fields to the opcode decoder. It then consumes the decoder's PCWre/PCSrc result to choose the next PC or to halt. It is the producer side of the opcode→control-signal interface used by the single-cycle core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
OP_JMP, 6'b110010, opcode treated as jump when pc_src=1.
OP_HALT, 6'b111111, opcode; informational only, halt is signalled via pc_wre.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  level; leaves IDLE when high.
imem_req  out  1  fetch request; held high until ack.
imem_addr  out  32  byte address of the instruction = pc.
imem_ack  in  1  imem_rdata is valid this cycle.
imem_rdata  in  32  instruction word.
instr_valid  out  1  high for exactly the one EXEC cycle; IR fields are valid.
operation  out  6  IR[31:26], to the decoder.
rs / rt / rd  out  5 each  IR[25:21] / IR[20:16] / IR[15:11].
imm16  out  16  IR[15:0].
pc_out  out  32  address of the instruction in IR.
pc_wre  in  1  from decoder, sampled in EXEC only; 0 = halt.
pc_src  in  1  from decoder, sampled in EXEC only; 1 = take branch/jump.
halted  out  1  high in HALTED state.
retired  out  32  count of instructions completing EXEC with pc_wre=1; wraps at 2^32.

Behaviour:
- States: IDLE, FETCH, EXEC, HALTED. Encoding 2 bits.
- Reset values: state=IDLE, pc=RESET_PC, IR=0, retired=0. All outputs are 0 except imem_addr=pc_out=RESET_PC.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On the cycle imem_ack=1, IR<=imem_rdata and state goes to EXEC. Otherwise stay, with req and addr held stable.
- An imem_ack arriving outside FETCH is ignored; IR is unchanged.
- Minimum fetch latency: ack in the first FETCH cycle gives FETCH=1 cycle, then EXEC.
- EXEC: instr_valid=1, fields driven from IR, pc_out=pc. The decoder and datapath commit combinationally this cycle.
- Next PC, computed in EXEC:
  - pc4 = pc+4, modulo 2^32.
  - pc_src=0: next = pc4.
  - pc_src=1 and operation==OP_JMP: next = {pc4[31:28], IR[25:0], 2'b00}.
  - pc_src=1 and any other opcode: next = pc4 + (sign_extend(imm16)<<2), modulo 2^32.
- End of EXEC with pc_wre=1: pc<=next, retired<=retired+1, state goes to FETCH.
- End of EXEC with pc_wre=0: pc unchanged, retired unchanged, state goes to HALTED.
- HALTED: halted=1, imem_req=0, instr_valid=0. The block stays here until reset; run is ignored.
- pc_wre and pc_src are ignored in every state other than EXEC.
- Reset asserted mid-FETCH: imem_req drops the cycle after the reset edge, and a same-cycle ack is discarded. A late ack after reset is ignored because the state is IDLE.
- run deasserted after leaving IDLE has no effect; the block runs until halt.
- Address wrap: pc 32'hFFFF_FFFC with a sequential PC gives 32'h0000_0000. There is no alignment fault, because all targets are word aligned by construction.

Decomposition:
- Shared core package: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_JMP, OP_HALT), the fetch state encoding, and instruction field bit positions.
- One sub-module, next_pc_calc: purely combinational, inputs pc, IR, pc_src; output next. It is reused by the multi-cycle variant.
- The FSM, PC, IR and retire counter stay in the top module.

Test Plan:
- Reset then run=1, ack the first FETCH cycle with 32'h0000_0000 (ADD): instr_valid for one cycle with pc_out=0. With pc_wre=1, pc_src=0: next imem_addr=4, retired=1.
- Ack delayed 3 cycles: imem_req and imem_addr held stable for 3 cycles; EXEC occurs exactly one cycle after ack.
- pc=0x10, IR={6'b110000, …, imm16=16'hFFFE}, pc_src=1: next imem_addr=0x0C. With imm16=16'h0003: next imem_addr=0x20.
- pc=0x1000_0008, IR={6'b110010, 26'h000_0040}, pc_src=1: next imem_addr=0x1000_0100.
- EXEC with pc_wre=0: halted=1 next cycle and stays high, no further imem_req, retired unchanged. A later run pulse or stray ack changes nothing.
- reset during FETCH with ack coinciding: imem_req=0 after the edge, IR=0, pc=RESET_PC. pc=0xFFFF_FFFC sequential step: imem_addr=0.
